// File: rtl/cmd_pkg.sv
// Shared definitions for the host command interpreter: opcodes, response
// words, FSM state encoding and small helpers used when decoding commands.
package cmd_pkg;

  // Command opcodes, carried in bits [31:24] of each command word.
  localparam logic [7:0] OP_PING      = 8'h70;
  localparam logic [7:0] OP_READ      = 8'h52;
  localparam logic [7:0] OP_WRITE     = 8'h57;
  localparam logic [7:0] OP_CORE_CTRL = 8'h43;

  // Fixed response words sent back through the bridge.
  localparam logic [31:0] ACK_WORD = 32'h0000_00AA;
  localparam logic [31:0] NAK_WORD = 32'h0000_00FF;

  // FSM state encoding; kept as plain constants so older tooling and
  // waveform decoders that expect raw codes keep working.
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_FETCH_CMD  = 3'd1;
  localparam logic [2:0] ST_DECODE     = 3'd2;
  localparam logic [2:0] ST_FETCH_DATA = 3'd3;
  localparam logic [2:0] ST_MEM_ACCESS = 3'd4;
  localparam logic [2:0] ST_SEND       = 3'd5;
  localparam logic [2:0] ST_DRAIN      = 3'd6;

  // A command word split into its fields.
  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] arg;
  } cmd_word_t;

  // Word-aligned byte address derived from a 24-bit argument; the low two
  // bits are forced to zero and the top byte is always zero.
  function automatic logic [31:0] word_addr(input logic [23:0] arg);
    return {8'h00, arg & 24'hFF_FFFC};
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = 8'hFF;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cmd_interpreter.sv
// Host command interpreter: pulls 32-bit command words from the comm bridge,
// executes PING / READ / WRITE / CORE_CTRL against a simple request/ack memory
// port and returns exactly one response word per command. All outputs are
// registered; reset is synchronous and active-high.
module cmd_interpreter
  import cmd_pkg::*;
#(
  parameter logic [31:0] ID_WORD     = 32'h5043_4931,
  parameter int unsigned MEM_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  // comm bridge, receive side
  input  logic        comm_rx_empty,
  output logic        comm_read,
  input  logic        comm_read_response,
  input  logic [31:0] comm_read_data,
  // comm bridge, transmit side
  output logic        comm_write,
  output logic [31:0] comm_write_data,
  input  logic        comm_write_response,
  // memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  // status / control
  output logic        core_reset,
  output logic [7:0]  err_count
);

  // Timeout counter counts request cycles 0 .. MEM_TIMEOUT-1.
  localparam int unsigned        TMR_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0]   TMR_ZERO = {TMR_W{1'b0}};

  logic [2:0]       state_q, state_d;
  cmd_word_t        cmd_q, cmd_d;
  logic             rd_pend_q, rd_pend_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic             comm_read_q, comm_read_d;
  logic             comm_write_q, comm_write_d;
  logic [31:0]      comm_write_data_q, comm_write_data_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             core_reset_q, core_reset_d;
  logic [7:0]       err_count_q, err_count_d;

  // Next-state and next-output logic for the single command FSM.
  always_comb begin
    state_d           = state_q;
    cmd_d             = cmd_q;
    rd_pend_d         = rd_pend_q;
    tmr_d             = tmr_q;
    comm_read_d       = 1'b0;
    comm_write_d      = 1'b0;
    comm_write_data_d = comm_write_data_q;
    mem_req_d         = mem_req_q;
    mem_we_d          = mem_we_q;
    mem_addr_d        = mem_addr_q;
    mem_wdata_d       = mem_wdata_q;
    core_reset_d      = core_reset_q;
    err_count_d       = err_count_q;

    case (state_q)
      // Wait for a command word; one read pulse, then wait for its data.
      ST_IDLE: begin
        if (!comm_rx_empty) begin
          comm_read_d = 1'b1;
          state_d     = ST_FETCH_CMD;
        end else begin
          state_d     = ST_IDLE;
        end
      end

      // Capture on the first response cycle. A second response cycle lands
      // in DECODE, which never looks at the bridge, so it is ignored.
      ST_FETCH_CMD: begin
        if (comm_read_response) begin
          cmd_d   = comm_read_data;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH_CMD;
        end
      end

      ST_DECODE: begin
        case (cmd_q.opcode)
          OP_PING: begin
            comm_write_d      = 1'b1;
            comm_write_data_d = ID_WORD;
            state_d           = ST_SEND;
          end
          OP_READ: begin
            mem_addr_d = word_addr(cmd_q.arg);
            mem_we_d   = 1'b0;
            mem_req_d  = 1'b1;
            tmr_d      = TMR_ZERO;
            state_d    = ST_MEM_ACCESS;
          end
          OP_WRITE: begin
            // Address is latched now; the request waits for the data word.
            mem_addr_d = word_addr(cmd_q.arg);
            rd_pend_d  = 1'b0;
            state_d    = ST_FETCH_DATA;
          end
          OP_CORE_CTRL: begin
            core_reset_d      = cmd_q.arg[0];
            comm_write_d      = 1'b1;
            comm_write_data_d = ACK_WORD;
            state_d           = ST_SEND;
          end
          default: begin
            err_count_d       = sat_inc8(err_count_q);
            comm_write_d      = 1'b1;
            comm_write_data_d = NAK_WORD;
            state_d           = ST_SEND;
          end
        endcase
      end

      // Fetch the WRITE payload. No timeout: the host may be slow to send it.
      ST_FETCH_DATA: begin
        if (rd_pend_q) begin
          if (comm_read_response) begin
            mem_wdata_d = comm_read_data;
            mem_we_d    = 1'b1;
            mem_req_d   = 1'b1;
            tmr_d       = TMR_ZERO;
            rd_pend_d   = 1'b0;
            state_d     = ST_MEM_ACCESS;
          end else begin
            state_d     = ST_FETCH_DATA;
          end
        end else if (!comm_rx_empty) begin
          comm_read_d = 1'b1;
          rd_pend_d   = 1'b1;
          state_d     = ST_FETCH_DATA;
        end else begin
          state_d     = ST_FETCH_DATA;
        end
      end

      // Hold the request until ack or until the timeout budget is spent.
      // Any trailing read-response cycle from FETCH_DATA is ignored here.
      ST_MEM_ACCESS: begin
        if (mem_ack) begin
          mem_req_d         = 1'b0;
          comm_write_d      = 1'b1;
          comm_write_data_d = mem_we_q ? ACK_WORD : mem_rdata;
          state_d           = ST_SEND;
        end else if (tmr_q == TMR_LAST) begin
          mem_req_d         = 1'b0;
          err_count_d       = sat_inc8(err_count_q);
          comm_write_d      = 1'b1;
          comm_write_data_d = NAK_WORD;
          state_d           = ST_SEND;
        end else begin
          tmr_d             = tmr_q + TMR_ONE;
          state_d           = ST_MEM_ACCESS;
        end
      end

      // Response word is held until the bridge accepts it.
      ST_SEND: begin
        if (comm_write_response) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_SEND;
        end
      end

      // Swallows a possible second write-response cycle before going idle.
      ST_DRAIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        mem_req_d = 1'b0;
        rd_pend_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      cmd_q             <= 32'h0000_0000;
      rd_pend_q         <= 1'b0;
      tmr_q             <= TMR_ZERO;
      comm_read_q       <= 1'b0;
      comm_write_q      <= 1'b0;
      comm_write_data_q <= 32'h0000_0000;
      mem_req_q         <= 1'b0;
      mem_we_q          <= 1'b0;
      mem_addr_q        <= 32'h0000_0000;
      mem_wdata_q       <= 32'h0000_0000;
      core_reset_q      <= 1'b1;
      err_count_q       <= 8'h00;
    end else begin
      state_q           <= state_d;
      cmd_q             <= cmd_d;
      rd_pend_q         <= rd_pend_d;
      tmr_q             <= tmr_d;
      comm_read_q       <= comm_read_d;
      comm_write_q      <= comm_write_d;
      comm_write_data_q <= comm_write_data_d;
      mem_req_q         <= mem_req_d;
      mem_we_q          <= mem_we_d;
      mem_addr_q        <= mem_addr_d;
      mem_wdata_q       <= mem_wdata_d;
      core_reset_q      <= core_reset_d;
      err_count_q       <= err_count_d;
    end
  end

  assign comm_read       = comm_read_q;
  assign comm_write      = comm_write_q;
  assign comm_write_data = comm_write_data_q;
  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign core_reset      = core_reset_q;
  assign err_count       = err_count_q;

endmodule
